// File: rtl/wishbone_master_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wishbone_master_ctrl_pkg
// Shared definitions for the Wishbone master controller:
//   - bus widths (address, data) and timeout counter width
//   - FSM state encoding
//   - slave address map
// -----------------------------------------------------------------------------
package wishbone_master_ctrl_pkg;

    localparam int ADR_W     = 5;
    localparam int DATA_W    = 128;
    localparam int TIMEOUT_W = 8;    // wide enough for TIMEOUT_CYCLES up to 255

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_RESP   = 2'd2
    } wb_state_e;

    // Slave address map
    localparam logic [ADR_W-1:0] ADR_CTRL     = 5'h00;
    localparam logic [ADR_W-1:0] ADR_STATUS   = 5'h01;
    localparam logic [ADR_W-1:0] ADR_IRQ_MASK = 5'h02;
    localparam logic [ADR_W-1:0] ADR_CONFIG   = 5'h03;
    localparam logic [ADR_W-1:0] ADR_FIFO     = 5'h10;

endpackage

// File: rtl/wishbone_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// wishbone_master_ctrl_if
// Wishbone bus between the master controller and one slave. Signal names are
// taken from the master's point of view:
//   we_o, adr_o, strobe_o, wb_data_o : master -> slave (slave we_i/adr_i/strobe/wb_data_i)
//   wb_data_i, ack_i, error_i        : slave -> master (slave wb_data_o/ack_o/error_o)
// Modports: master (controller side), slave (peripheral side).
// -----------------------------------------------------------------------------
interface wishbone_master_ctrl_if;
    import wishbone_master_ctrl_pkg::*;

    logic              we_o;
    logic [ADR_W-1:0]  adr_o;
    logic              strobe_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [DATA_W-1:0] wb_data_i;
    logic              ack_i;
    logic              error_i;

    modport master (
        output we_o, adr_o, strobe_o, wb_data_o,
        input  wb_data_i, ack_i, error_i
    );

    modport slave (
        input  we_o, adr_o, strobe_o, wb_data_o,
        output wb_data_i, ack_i, error_i
    );

endinterface

// File: rtl/wishbone_master_ctrl_timeout_counter.sv
// -----------------------------------------------------------------------------
// wb_timeout_counter
// Counts strobe cycles of one Wishbone transaction and flags the last allowed
// cycle. Only instantiated when WB_MASTER_TIMEOUT_EN is defined.
// Ports:
//   clock     : system clock, rising edge
//   reset     : synchronous active-high reset
//   clear_i   : restart the count (transaction accepted)
//   enable_i  : count this cycle (strobe active)
//   expired_o : current strobe cycle is cycle number LIMIT
// -----------------------------------------------------------------------------
module wb_timeout_counter
    import wishbone_master_ctrl_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [TIMEOUT_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            r_count <= '0;
        end else if (enable_i) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

    // The count holds the number of strobe cycles already completed, so a value
    // of LIMIT-1 marks the LIMIT-th strobe cycle.
    assign expired_o = enable_i && (r_count == TIMEOUT_W'(LIMIT - 1));

endmodule

// File: rtl/wishbone_master_ctrl.sv
// -----------------------------------------------------------------------------
// wishbone_master_ctrl
// Single-outstanding Wishbone master. A client request is registered onto the
// bus, strobe is held until the slave acks or errors, then a one-cycle response
// pulse reports read data / error / timeout.
// Optional feature macro: WB_MASTER_TIMEOUT_EN (abort after TIMEOUT_CYCLES
// strobe cycles without ack/error; otherwise strobe waits indefinitely).
// Ports:
//   clock, reset                 : system clock, synchronous active-high reset
//   req_valid_i/we/adr/data      : client request
//   req_ready_o                  : request can be accepted this cycle
//   resp_valid_o                 : one-cycle completion pulse
//   resp_data_o                  : last successfully read data
//   resp_error_o, resp_timeout_o : completion status, valid with resp_valid_o
//   wb                           : Wishbone bus (master modport)
// -----------------------------------------------------------------------------
module wishbone_master_ctrl
    import wishbone_master_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [ADR_W-1:0]  req_adr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              req_ready_o,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_error_o,
    output logic              resp_timeout_o,
    wishbone_master_ctrl_if.master wb
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..255");
    end

    wb_state_e         r_state;
    wb_state_e         w_state_next;
    logic              w_ready;
    logic              w_strobe;
    logic              w_valid;
    logic              w_accept;
    logic              w_slave_done;
    logic              w_expired;
    logic              w_complete;

    logic              r_we;
    logic [ADR_W-1:0]  r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_error;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_strobe     = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (req_valid_i) begin
                    w_state_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_strobe = 1'b1;
                // ack/error on the last counted cycle still completes normally;
                // the status registers below give it priority over timeout.
                if (w_slave_done || w_expired) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_valid      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept     = w_ready & req_valid_i;
    // ack/error only matter while strobing; they are ignored in IDLE and RESP.
    assign w_slave_done = wb.ack_i | wb.error_i;
    assign w_complete   = w_strobe & (w_slave_done | w_expired);

    // -------------------------------------------------------------------------
    // Bus and response registers
    // -------------------------------------------------------------------------
    // NOTE: the wide data registers are reset explicitly because their reset
    // value is architecturally visible (resp_data_o reads 0 after reset).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we_i;
                r_adr   <= req_adr_i;
                r_wdata <= req_data_i;
            end
            if (w_complete) begin
                // ack together with error counts as an error.
                r_error <= wb.error_i;
                if (wb.ack_i && !wb.error_i && !r_we) begin
                    r_rdata <= wb.wb_data_i;
                end
            end
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    logic r_timeout;

    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (w_accept),
        .enable_i  (w_strobe),
        .expired_o (w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_complete) begin
            r_timeout <= w_expired & ~w_slave_done;
        end
    end

    assign resp_timeout_o = r_timeout;
`else
    assign w_expired      = 1'b0;
    assign resp_timeout_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready_o  = w_ready & ~reset;
    assign resp_valid_o = w_valid;
    assign resp_data_o  = r_rdata;
    assign resp_error_o = r_error;

    assign wb.we_o      = r_we;
    assign wb.adr_o     = r_adr;
    assign wb.wb_data_o = r_wdata;
    assign wb.strobe_o  = w_strobe;

endmodule

// File: tb/tb_wishbone_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wishbone_master_ctrl
// Self-checking bench: stimulus issues requests and plays the slave, pushing
// the expected response into a scoreboard queue; an independent monitor pops
// and compares whenever resp_valid_o is seen.
// -----------------------------------------------------------------------------
module tb_wishbone_master_ctrl;
    import wishbone_master_ctrl_pkg::*;

    localparam int TMO = 16;

    typedef enum int { K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3 } kind_e;

    typedef struct {
        logic              err;
        logic              tmo;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic              clock;
    logic              reset;
    logic              req_valid_i;
    logic              req_we_i;
    logic [ADR_W-1:0]  req_adr_i;
    logic [DATA_W-1:0] req_data_i;
    logic              req_ready_o;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_data_o;
    logic              resp_error_o;
    logic              resp_timeout_o;

    wishbone_master_ctrl_if wb ();

    wishbone_master_ctrl #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .req_we_i       (req_we_i),
        .req_adr_i      (req_adr_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .resp_error_o   (resp_error_o),
        .resp_timeout_o (resp_timeout_o),
        .wb             (wb)
    );

    int                n_cmp;
    int                n_fail;
    resp_t             exp_q[$];
    logic [DATA_W-1:0] model_rdata;   // last successfully read value
    logic [ADR_W-1:0]  adr_map [5];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, {127'b0, act}, {127'b0, exp});
    endtask

    function automatic logic [DATA_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // -------------------------------------------------------------------------
    // One transaction: issue request, act as slave, check bus-side behaviour.
    // ---------------------------------------------------------------------------
    task automatic run_txn(input logic we, input logic [ADR_W-1:0] adr,
                           input logic [DATA_W-1:0] wdata, input int wait_n,
                           input kind_e kind, input logic [DATA_W-1:0] rdata,
                           input logic hold_valid, output int accept_wait);
        resp_t e;
        int    strobes;
        int    exp_strobes;
        logic  bus_bad;
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_adr_i   = adr;
        req_data_i  = wdata;
        accept_wait = 0;
        while (!req_ready_o && accept_wait < 8) begin
            @(negedge clock);
            accept_wait++;
        end
        chk1("req_ready_to_accept", req_ready_o, 1'b1);
        if (!req_ready_o) begin
            req_valid_i = 1'b0;
            return;
        end
        e.err = (kind == K_ERR || kind == K_BOTH);
        e.tmo = (kind == K_NONE);
        if (kind == K_ACK && !we) model_rdata = rdata;
        e.data = model_rdata;
        exp_q.push_back(e);
        exp_strobes = (kind == K_NONE) ? TMO : wait_n + 1;

        @(negedge clock);
        if (hold_valid) begin
            // Keep valid asserted with unrelated contents: nothing may be taken
            // until the controller is ready again.
            req_we_i   = 1'($urandom);
            req_adr_i  = ADR_W'($urandom);
            req_data_i = rand128();
        end else begin
            req_valid_i = 1'b0;
        end

        strobes = 0;
        bus_bad = 1'b0;
        while (wb.strobe_o && strobes < 200) begin
            strobes++;
            if (wb.we_o !== we || wb.adr_o !== adr || wb.wb_data_o !== wdata) bus_bad = 1'b1;
            wb.ack_i     = 1'b0;
            wb.error_i   = 1'b0;
            wb.wb_data_i = rand128();
            if (kind != K_NONE && strobes == wait_n + 1) begin
                wb.ack_i     = (kind != K_ERR);
                wb.error_i   = (kind != K_ACK);
                wb.wb_data_i = rdata;
            end
            @(negedge clock);
        end
        // Response cycle: slave noise here must be ignored.
        wb.ack_i     = 1'($urandom);
        wb.error_i   = 1'($urandom);
        wb.wb_data_i = rand128();
        check("strobe_cycles", 128'(strobes), 128'(exp_strobes));
        chk1("bus_stable", bus_bad, 1'b0);
        chk1("resp_valid_in_resp", resp_valid_o, 1'b1);
        chk1("ready_low_in_resp", req_ready_o, 1'b0);
        @(negedge clock);
        wb.ack_i     = 1'($urandom);
        wb.error_i   = 1'($urandom);
        wb.wb_data_i = rand128();
        chk1("ready_after_resp", req_ready_o, 1'b1);
    endtask

    // Accept a read, hold strobe without answer for n cycles, then reset.
    task automatic reset_during_strobe(input int n);
        int seen;
        int waited;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_adr_i   = ADR_FIFO;
        req_data_i  = rand128();
        waited = 0;
        while (!req_ready_o && waited < 8) begin
            @(negedge clock);
            waited++;
        end
        @(negedge clock);
        req_valid_i = 1'b0;
        wb.ack_i    = 1'b0;
        wb.error_i  = 1'b0;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (wb.strobe_o) seen++;
            if (i != n - 1) @(negedge clock);
        end
        check("strobe_held_no_ack", 128'(seen), 128'(n));
        reset = 1'b1;
        @(negedge clock);
        chk1("rst_strobe_dropped", wb.strobe_o, 1'b0);
        chk1("rst_ready_low", req_ready_o, 1'b0);
        chk1("rst_no_resp", resp_valid_o, 1'b0);
        chk1("rst_we", wb.we_o, 1'b0);
        check("rst_adr", 128'(wb.adr_o), '0);
        check("rst_wdata", wb.wb_data_o, '0);
        check("rst_resp_data", resp_data_o, '0);
        model_rdata = '0;
        reset = 1'b0;
        @(negedge clock);
        chk1("ready_after_reset_release", req_ready_o, 1'b1);
        chk1("idle_after_reset", wb.strobe_o, 1'b0);
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    initial begin
        logic  prev_valid;
        resp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (resp_valid_o) begin
                chk1("resp_single_cycle", prev_valid, 1'b0);
                if (exp_q.size() == 0) begin
                    chk1("resp_unexpected", resp_valid_o, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", resp_data_o, e.data);
                    chk1("resp_error", resp_error_o, e.err);
                    chk1("resp_timeout", resp_timeout_o, e.tmo);
                end
            end
            prev_valid = resp_valid_o;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int    aw;
        int    gap;
        logic  hold;
        logic  prev_hold;
        kind_e kind;
        int    max_kind;

        n_cmp       = 0;
        n_fail      = 0;
        model_rdata = '0;
        adr_map[0]  = ADR_CTRL;
        adr_map[1]  = ADR_STATUS;
        adr_map[2]  = ADR_IRQ_MASK;
        adr_map[3]  = ADR_CONFIG;
        adr_map[4]  = ADR_FIFO;

        reset        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_adr_i    = '0;
        req_data_i   = '0;
        wb.ack_i     = 1'b0;
        wb.error_i   = 1'b0;
        wb.wb_data_i = '0;

        repeat (3) @(negedge clock);
        chk1("reset_ready", req_ready_o, 1'b0);
        chk1("reset_strobe", wb.strobe_o, 1'b0);
        chk1("reset_we", wb.we_o, 1'b0);
        check("reset_adr", 128'(wb.adr_o), '0);
        check("reset_wdata", wb.wb_data_o, '0);
        chk1("reset_resp_valid", resp_valid_o, 1'b0);
        check("reset_resp_data", resp_data_o, '0);
        chk1("reset_resp_error", resp_error_o, 1'b0);
        chk1("reset_resp_timeout", resp_timeout_o, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        chk1("ready_after_init_reset", req_ready_o, 1'b1);

        // Write with ack one cycle after strobe starts
        run_txn(1'b1, 5'h03, {16{8'hA5}}, 1, K_ACK, rand128(), 1'b0, aw);
        // Read with same-cycle ack (minimum latency)
        run_txn(1'b0, 5'h10, '0, 0, K_ACK,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, aw);
        // ack and error together: error, read data kept
        run_txn(1'b0, 5'h10, '0, 2, K_BOTH, rand128(), 1'b0, aw);
        // error only on a read
        run_txn(1'b0, ADR_STATUS, '0, 0, K_ERR, rand128(), 1'b0, aw);
        // Write leaves read data alone
        run_txn(1'b1, ADR_CTRL, rand128(), 3, K_ACK, rand128(), 1'b0, aw);

        // Back-to-back with valid held high
        run_txn(1'b0, ADR_CONFIG, '0, 0, K_ACK, rand128(), 1'b1, aw);
        run_txn(1'b0, ADR_FIFO, '0, 0, K_ACK, rand128(), 1'b0, aw);
        check("b2b_accept_wait", 128'(aw), '0);

        // Reset in the fourth strobe cycle
        reset_during_strobe(4);

`ifdef WB_MASTER_TIMEOUT_EN
        run_txn(1'b0, ADR_FIFO, '0, 0, K_NONE, '0, 1'b0, aw);
        run_txn(1'b0, ADR_FIFO, '0, TMO - 1, K_ACK, rand128(), 1'b0, aw);
        run_txn(1'b1, ADR_CTRL, rand128(), TMO - 1, K_ERR, rand128(), 1'b0, aw);
        max_kind = 3;
`else
        // No timeout: strobe must stay up indefinitely
        reset_during_strobe(120);
        max_kind = 2;
`endif

        // Randomized traffic
        prev_hold = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!prev_hold) begin
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clock);
            end
            hold = (i != 59) ? 1'($urandom) : 1'b0;
            kind = kind_e'($urandom_range(0, max_kind));
            run_txn(1'($urandom), adr_map[$urandom_range(0, 4)], rand128(),
                    $urandom_range(0, 5), kind, rand128(), hold, aw);
            prev_hold = hold;
        end

        req_valid_i = 1'b0;
        wb.ack_i    = 1'b0;
        wb.error_i  = 1'b0;
        repeat (4) @(negedge clock);
        check("scoreboard_drained", 128'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wishbone_master_ctrl.md
WISHBONE_MASTER_CTRL -- requirements
Module: wishbone_master_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max strobe-high cycles before abort (range 2..255).
REQ-002 SHALL have port clock  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid_i  in  1  client request pending.
REQ-005 SHALL have port req_we_i  in  1  1 = write, 0 = read.
REQ-006 SHALL have port req_adr_i  in  5  target register/FIFO address.
REQ-007 SHALL have port req_data_i  in  128  write data.
REQ-008 SHALL have port req_ready_o  out  1  block can accept a request.
REQ-009 SHALL have port resp_valid_o  out  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_data_o  out  128  read data captured on ack.
REQ-011 SHALL have port resp_error_o  out  1  slave signalled error.
REQ-012 SHALL have port resp_timeout_o  out  1  transaction aborted on timeout.
REQ-013 SHALL have ports we_o (out 1), adr_o (out 5), strobe_o (out 1), wb_data_o (out 128) driving the Wishbone slave's we_i, adr_i, strobe, wb_data_i.
REQ-014 SHALL have ports wb_data_i (in 128), ack_i (in 1), error_i (in 1) fed from the slave's wb_data_o, ack_o, error_o.

Function
REQ-015 SHALL implement FSM states IDLE, STROBE, RESP.
REQ-016 IDLE: req_ready_o=1; on req_valid_i=1, SHALL register we/adr/data into we_o/adr_o/wb_data_o and go to STROBE.
REQ-017 STROBE: strobe_o=1, req_ready_o=0; we_o/adr_o/wb_data_o SHALL stay stable throughout.
REQ-018 STROBE: on ack_i=1 or error_i=1, SHALL go to RESP, drop strobe_o the next cycle, and capture wb_data_i into resp_data_o when ack_i=1 and we_o=0.
REQ-019 ack_i and error_i both high in the same cycle SHALL be treated as error: resp_error_o=1, resp_data_o not updated.
REQ-020 RESP: resp_valid_o=1 for exactly one cycle with resp_error_o/resp_timeout_o valid; then IDLE.
REQ-021 Minimum request-to-resp_valid latency SHALL be 3 cycles (accept, strobe with same-cycle ack, RESP).
REQ-022 Back-to-back: req_ready_o SHALL return to 1 the cycle after RESP; no request accepted during STROBE or RESP.
REQ-023 ack_i/error_i outside STROBE SHALL be ignored.
REQ-024 resp_data_o SHALL hold its last value until the next successful read.
REQ-025 Write requests SHALL leave resp_data_o unchanged.

Reset
REQ-026 reset=1 SHALL force IDLE in the same edge, including mid-STROBE, abandoning the transaction with no resp_valid_o.
REQ-027 Reset values: strobe_o=0, we_o=0, adr_o=0, wb_data_o=0, resp_valid_o=0, resp_data_o=0, resp_error_o=0, resp_timeout_o=0, timeout counter=0; req_ready_o=0 while reset high, 1 the cycle after.

Configuration
REQ-028 Macro WB_MASTER_TIMEOUT_EN defined: counter increments each STROBE cycle; if it reaches TIMEOUT_CYCLES with no ack/error, SHALL go to RESP with resp_timeout_o=1, resp_error_o=0.
REQ-029 Counter SHALL clear on entering STROBE; ack/error on the final counted cycle SHALL take priority over timeout.
REQ-030 Macro undefined: no counter logic; STROBE waits indefinitely; resp_timeout_o tied to 0.

Structure
REQ-031 Shared package SHALL hold ADR_W=5, DATA_W=128, FSM state encodings, and the slave address map constants.
REQ-032 Timeout counter SHALL be sub-module wb_timeout_counter (inputs clear, enable; output expired), instantiated only under WB_MASTER_TIMEOUT_EN.

Verification
REQ-033 Write adr=5'h03 data=128'hA5..A5, ack_i one cycle after strobe -> we_o=1, adr_o=3, strobe 2 cycles, resp_valid_o once, resp_error_o=0.
REQ-034 Read adr=5'h10, ack_i with wb_data_i=128'h0123_4567_89AB_CDEF_... -> resp_data_o equals that value on resp_valid_o.
REQ-035 ack_i and error_i high together -> resp_error_o=1, resp_data_o keeps previous value.
REQ-036 With WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> strobe_o high exactly 16 cycles, resp_timeout_o=1; without macro strobe stays high 100+ cycles.
REQ-037 reset pulsed during STROBE cycle 4 -> strobe_o=0 next cycle, no resp_valid_o, req_ready_o=1 after reset release.
REQ-038 Two back-to-back requests with req_valid_i held high -> second accepted cycle after first RESP, adr_o switches cleanly.
